// File: rtl/vertexinput_axil_regs_if.sv
// Register-side link between the AXI-lite register block and the vertex-input logic:
// config flows mem->logic, status flows logic->mem.
`ifndef DATA_W
`define DATA_W 32
`endif

interface vertexinput_reg_if #(
  parameter int DATA_W = `DATA_W
);
  logic [DATA_W-1:0] data_mem2logic;
  logic [DATA_W-1:0] data_logic2mem;

  modport mem_side   (output data_mem2logic, input data_logic2mem);
  modport logic_side (input data_mem2logic, output data_logic2mem);
endinterface

// File: rtl/vertexinput_axil_regs.sv
// AXI-lite slave exposing one RW CONFIG register and one RO STATUS register
// for the vertex-input stage; independent write and read FSMs.
`ifndef DATA_W
`define DATA_W 32
`endif

module vertexinput_axil_regs #(
  parameter int                DATA_W  = `DATA_W,
  parameter int                ADDR_W  = 4,
  parameter logic [DATA_W-1:0] CFG_RST = '0
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [ADDR_W-1:0]     s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_W-1:0]     s_axi_wdata,
  input  logic [DATA_W/8-1:0]   s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_W-1:0]     s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [DATA_W-1:0]     s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  vertexinput_reg_if.mem_side   reg_if
);

  localparam int         STRB_W = DATA_W / 8;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] SEL_CONFIG = 2'd0;
  localparam logic [1:0] SEL_STATUS = 2'd1;

  typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_e;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

  w_state_e          w_state_q, w_state_d;
  r_state_e          r_state_q, r_state_d;
  logic [DATA_W-1:0] config_q, config_d;
  logic [DATA_W-1:0] status_q;
  logic [1:0]        bresp_q, bresp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic              w_accept;
  logic              r_accept;
  logic [DATA_W-1:0] config_merged;

  // Only the word select matters; byte offset and any upper bits are don't-care.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_awaddr, s_axi_araddr};

  generate
    for (genvar gi = 0; gi < STRB_W; gi++) begin : g_byte_merge
      assign config_merged[gi*8 +: 8] = s_axi_wstrb[gi] ? s_axi_wdata[gi*8 +: 8]
                                                        : config_q[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    w_state_d = w_state_q;
    config_d  = config_q;
    bresp_d   = bresp_q;
    w_accept  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        // Address and data are only taken together, so a lone channel never stalls the other.
        if (aresetn && s_axi_awvalid && s_axi_wvalid) begin
          w_accept  = 1'b1;
          w_state_d = W_RESP;
          if (s_axi_awaddr[3:2] == SEL_CONFIG) begin
            config_d = config_merged;
            bresp_d  = OKAY;
          end else begin
            bresp_d  = SLVERR;
          end
        end
      end
      W_RESP: begin
        if (s_axi_bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    r_accept  = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (aresetn && s_axi_arvalid) begin
          r_accept  = 1'b1;
          r_state_d = R_DATA;
          rresp_d   = OKAY;
          // config_q is the pre-edge value, so a same-cycle write is not yet visible here.
          case (s_axi_araddr[3:2])
            SEL_CONFIG: rdata_d = config_q;
            SEL_STATUS: rdata_d = status_q;
            default: begin
              rdata_d = '0;
              rresp_d = SLVERR;
            end
          endcase
        end
      end
      R_DATA: begin
        if (s_axi_rready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      config_q  <= CFG_RST;
      status_q  <= '0;
      bresp_q   <= OKAY;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      config_q  <= config_d;
      status_q  <= reg_if.data_logic2mem;
      bresp_q   <= bresp_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign s_axi_awready = w_accept;
  assign s_axi_wready  = w_accept;
  assign s_axi_bvalid  = (w_state_q == W_RESP);
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = aresetn && (r_state_q == R_IDLE);
  assign s_axi_rvalid  = (r_state_q == R_DATA);
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;

  assign reg_if.data_mem2logic = config_q;

  logic unused_r_accept;
  assign unused_r_accept = r_accept;

endmodule

// File: tb/tb_vertexinput_axil_regs.sv
// Self-checking bench for vertexinput_axil_regs: directed scenarios plus a
// randomized write/read mix checked against a register-map reference model.
module tb_vertexinput_axil_regs;

  localparam int          DW      = 32;
  localparam int          AW      = 4;
  localparam logic [31:0] CFG_RST = 32'h0000_00C3;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [AW-1:0] awaddr = '0;
  logic          awvalid = 1'b0;
  logic          awready;
  logic [DW-1:0] wdata = '0;
  logic [3:0]    wstrb = '0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready = 1'b0;
  logic [AW-1:0] araddr = '0;
  logic          arvalid = 1'b0;
  logic          arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready = 1'b0;

  vertexinput_reg_if #(.DATA_W(DW)) rif ();

  vertexinput_axil_regs #(.DATA_W(DW), .ADDR_W(AW), .CFG_RST(CFG_RST)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .reg_if(rif)
  );

  always #5 aclk = ~aclk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: register contents as the spec's address map defines them.
  logic [31:0] m_cfg;
  logic [31:0] m_status;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] strb);
    logic [31:0] m = 32'h0;
    for (int b = 0; b < 4; b++) if (strb[b]) m = m | (32'hFF << (8 * b));
    return (old & ~m) | (data & m);
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] addr);
    int word = int'(addr) / 4;
    if (word == 0) return m_cfg;
    if (word == 1) return m_status;
    return 32'h0;
  endfunction

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic [1:0] exp_resp;
    exp_resp = (int'(addr) / 4 == 0) ? 2'b00 : 2'b10;
    if (exp_resp == 2'b00) m_cfg = merge(m_cfg, data, strb);
    @(negedge aclk);
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    #1;
    check_eq("wr_awready", 32'(awready), 32'd1);
    check_eq("wr_wready", 32'(wready), 32'd1);
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0;
    check_eq("wr_bvalid", 32'(bvalid), 32'd1);
    check_eq("wr_bresp", 32'(bresp), 32'(exp_resp));
    check_eq("wr_cfg", rif.data_mem2logic, m_cfg);
    $display("WR addr=0x%01h data=0x%08h strb=0x%01h bresp=%0d cfg=0x%08h",
             addr, data, strb, bresp, rif.data_mem2logic);
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    check_eq("wr_bvalid_drop", 32'(bvalid), 32'd0);
  endtask

  task automatic axi_read(input logic [3:0] addr);
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    exp_data = model_read(addr);
    exp_resp = (int'(addr) / 4 <= 1) ? 2'b00 : 2'b10;
    @(negedge aclk);
    araddr = addr; arvalid = 1'b1;
    #1;
    check_eq("rd_arready", 32'(arready), 32'd1);
    @(negedge aclk);
    arvalid = 1'b0;
    check_eq("rd_rvalid", 32'(rvalid), 32'd1);
    check_eq("rd_rdata", rdata, exp_data);
    check_eq("rd_rresp", 32'(rresp), 32'(exp_resp));
    $display("RD addr=0x%01h rdata=0x%08h rresp=%0d", addr, rdata, rresp);
    rready = 1'b1;
    @(negedge aclk);
    rready = 1'b0;
    check_eq("rd_rvalid_drop", 32'(rvalid), 32'd0);
  endtask

  initial begin
    logic [31:0] held_bresp;
    rif.data_logic2mem = 32'hDEAD_BEEF;
    m_status = 32'hDEAD_BEEF;
    m_cfg    = CFG_RST;

    // Reset: handshakes offered must not be taken.
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    repeat (3) @(negedge aclk);
    check_eq("rst_awready", 32'(awready), 32'd0);
    check_eq("rst_wready", 32'(wready), 32'd0);
    check_eq("rst_arready", 32'(arready), 32'd0);
    check_eq("rst_bvalid", 32'(bvalid), 32'd0);
    check_eq("rst_rvalid", 32'(rvalid), 32'd0);
    check_eq("rst_bresp", 32'(bresp), 32'd0);
    check_eq("rst_rresp", 32'(rresp), 32'd0);
    check_eq("rst_rdata", rdata, 32'd0);
    check_eq("rst_cfg", rif.data_mem2logic, CFG_RST);
    $display("RST checked cfg=0x%08h", rif.data_mem2logic);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    aresetn = 1'b1;
    #1;
    check_eq("post_rst_arready", 32'(arready), 32'd1);
    check_eq("post_rst_awready", 32'(awready), 32'd0);

    axi_read(4'h0);
    axi_write(4'h0, 32'hA5A5_1234, 4'hF);
    check_eq("dir_cfg_a5a5", rif.data_mem2logic, 32'hA5A5_1234);
    axi_read(4'h0);

    axi_write(4'h0, 32'h0, 4'hF);
    axi_write(4'h0, 32'hFFFF_FFFF, 4'h5);
    check_eq("dir_cfg_strb5", rif.data_mem2logic, 32'h00FF_00FF);

    axi_read(4'h4);
    axi_write(4'h4, 32'h1234_5678, 4'hF);
    axi_read(4'h4);
    axi_read(4'hC);
    axi_read(4'h9);

    // Address arrives 3 cycles ahead of data; then response held with a second write pending.
    @(negedge aclk);
    awaddr = 4'h0; wdata = 32'h0BAD_F00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("aw_alone_awready", 32'(awready), 32'd0);
      check_eq("aw_alone_wready", 32'(wready), 32'd0);
      @(negedge aclk);
    end
    wvalid = 1'b1;
    m_cfg = 32'h0BAD_F00D;
    #1;
    check_eq("aw_joined_awready", 32'(awready), 32'd1);
    @(negedge aclk);
    wdata = 32'h1111_2222;
    held_bresp = 32'(bresp);
    check_eq("hold_bresp_first", held_bresp, 32'd0);
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("hold_bvalid", 32'(bvalid), 32'd1);
      check_eq("hold_bresp", 32'(bresp), held_bresp);
      check_eq("hold_awready", 32'(awready), 32'd0);
      check_eq("hold_cfg", rif.data_mem2logic, m_cfg);
      @(negedge aclk);
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    check_eq("hold_release_bvalid", 32'(bvalid), 32'd0);
    check_eq("hold_release_cfg", rif.data_mem2logic, 32'h0BAD_F00D);
    $display("HOLD write accepted after data, response held 4 cycles");

    // Same-cycle read and write of CONFIG: read sees the old value.
    axi_write(4'h0, 32'h7, 4'hF);
    @(negedge aclk);
    araddr = 4'h0; arvalid = 1'b1;
    awaddr = 4'h0; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    #1;
    check_eq("both_arready", 32'(arready), 32'd1);
    check_eq("both_awready", 32'(awready), 32'd1);
    @(negedge aclk);
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    check_eq("both_rdata_old", rdata, 32'h7);
    check_eq("both_rresp", 32'(rresp), 32'd0);
    check_eq("both_bvalid", 32'(bvalid), 32'd1);
    check_eq("both_cfg_new", rif.data_mem2logic, 32'h1);
    m_cfg = 32'h1;
    $display("BOTH rdata=0x%08h cfg=0x%08h", rdata, rif.data_mem2logic);
    bready = 1'b1; rready = 1'b1;
    @(negedge aclk);
    bready = 1'b0; rready = 1'b0;

    // Randomized mix against the model.
    for (int it = 0; it < 60; it++) begin
      logic [3:0]  a;
      logic [31:0] d;
      logic [3:0]  s;
      a = 4'($urandom_range(0, 15));
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      rif.data_logic2mem = $urandom;
      m_status = rif.data_logic2mem;
      if ($urandom_range(0, 1) == 0) axi_write(a, d, s);
      else axi_read(a);
    end

    // Reset while a CONFIG write response is outstanding.
    axi_write(4'h0, 32'h5555_AAAA, 4'hF);
    @(negedge aclk);
    awaddr = 4'h0; wdata = 32'h1234_4321; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0;
    check_eq("mid_rst_bvalid_pre", 32'(bvalid), 32'd1);
    #2;
    aresetn = 1'b0;
    #1;
    check_eq("mid_rst_bvalid", 32'(bvalid), 32'd0);
    check_eq("mid_rst_cfg", rif.data_mem2logic, CFG_RST);
    check_eq("mid_rst_arready", 32'(arready), 32'd0);
    m_cfg = CFG_RST;
    @(negedge aclk);
    aresetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("after_rst_bvalid", 32'(bvalid), 32'd0);
      check_eq("after_rst_rvalid", 32'(rvalid), 32'd0);
      @(negedge aclk);
    end
    $display("MIDRST response abandoned, cfg=0x%08h", rif.data_mem2logic);
    axi_read(4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
